// File: rtl/axi_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_bridge_pkg : shared encodings and fixed AXI3 fields for the      |
// |                  SRAM-to-AXI bridge.            Rev 1.0              |
// +----------------------------------------------------------------------+
package axi_bridge_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_R    = 2'd2
  } rstate_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_AW   = 2'd1,
    W_B    = 2'd2
  } wstate_t;

  localparam logic [3:0] ID_INST = 4'd0;
  localparam logic [3:0] ID_DATA = 4'd1;

  localparam logic [3:0] c_axi_len   = 4'd0;
  localparam logic [1:0] c_axi_burst = 2'd1;
  localparam logic [1:0] c_axi_lock  = 2'd0;
  localparam logic [3:0] c_axi_cache = 4'd0;
  localparam logic [2:0] c_axi_prot  = 3'd0;
  localparam logic [3:0] c_axi_wid   = 4'd1;
  // Instruction fetches are always full words.
  localparam logic [2:0] c_inst_size = 3'd2;

endpackage
`default_nettype wire

// File: rtl/sram_axi_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sram_axi_bridge : inst/data SRAM-like ports onto one AXI3 master,    |
// |                   independent read and write FSMs.  Rev 1.0          |
// +----------------------------------------------------------------------+
module sram_axi_bridge
  import axi_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  rstate_t     r_rstate, w_rstate_nxt;
  wstate_t     r_wstate, w_wstate_nxt;
  logic        r_data_busy;
  logic [31:0] r_araddr;
  logic [2:0]  r_arsize;
  logic [3:0]  r_arid;
  logic [31:0] r_awaddr;
  logic [2:0]  r_awsize;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_aw_done, r_w_done;

  logic w_data_rd_sel, w_data_rd_acc, w_data_wr_acc, w_inst_acc;
  logic w_aw_fire, w_w_fire, w_aw_ok, w_w_ok;
  logic w_unused;

  // A pending, non-blocked data read pre-empts the instruction port.
  assign w_data_rd_sel = ~reset & data_sram_req & ~data_sram_wr & ~r_data_busy;
  assign w_data_rd_acc = w_data_rd_sel & (r_rstate == R_IDLE);
  assign w_data_wr_acc = ~reset & data_sram_req & data_sram_wr & ~r_data_busy
                         & (r_wstate == W_IDLE);
  assign w_inst_acc    = ~reset & inst_sram_req & (r_rstate == R_IDLE) & ~w_data_rd_sel;

  assign w_aw_fire = awvalid & awready;
  assign w_w_fire  = wvalid & wready;
  assign w_aw_ok   = r_aw_done | w_aw_fire;
  assign w_w_ok    = r_w_done | w_w_fire;

  assign inst_sram_addr_ok = w_inst_acc;
  assign data_sram_addr_ok = w_data_rd_acc | w_data_wr_acc;
  assign inst_sram_data_ok = ~reset & (r_rstate == R_R) & rvalid & (rid == ID_INST);
  assign data_sram_data_ok = ~reset & (((r_rstate == R_R) & rvalid & (rid == ID_DATA))
                                       | ((r_wstate == W_B) & bvalid));
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;

  assign arid    = r_arid;
  assign araddr  = r_araddr;
  assign arsize  = r_arsize;
  assign arvalid = (r_rstate == R_AR);
  assign rready  = (r_rstate == R_R);
  assign arlen   = c_axi_len;
  assign arburst = c_axi_burst;
  assign arlock  = c_axi_lock;
  assign arcache = c_axi_cache;
  assign arprot  = c_axi_prot;

  assign awid    = c_axi_wid;
  assign awaddr  = r_awaddr;
  assign awsize  = r_awsize;
  assign awvalid = (r_wstate == W_AW) & ~r_aw_done;
  assign awlen   = c_axi_len;
  assign awburst = c_axi_burst;
  assign awlock  = c_axi_lock;
  assign awcache = c_axi_cache;
  assign awprot  = c_axi_prot;
  assign wid     = c_axi_wid;
  assign wdata   = r_wdata;
  assign wstrb   = r_wstrb;
  assign wlast   = 1'b1;
  assign wvalid  = (r_wstate == W_AW) & ~r_w_done;
  assign bready  = (r_wstate == W_B);

  assign w_unused = ^{inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata,
                      rresp, rlast, bid, bresp};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rstate <= R_IDLE;
      r_wstate <= W_IDLE;
    end else begin
      r_rstate <= w_rstate_nxt;
      r_wstate <= w_wstate_nxt;
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_data_rd_acc | w_inst_acc) w_rstate_nxt = R_AR;
      R_AR:    if (arready) w_rstate_nxt = R_R;
      R_R:     if (rvalid) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_data_wr_acc) w_wstate_nxt = W_AW;
      W_AW:    if (w_aw_ok & w_w_ok) w_wstate_nxt = W_B;
      W_B:     if (bvalid) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_araddr <= 32'd0;
      r_arsize <= 3'd0;
      r_arid   <= 4'd0;
    end else if (w_data_rd_acc) begin
      r_araddr <= data_sram_addr;
      r_arsize <= {1'b0, data_sram_size};
      r_arid   <= ID_DATA;
    end else if (w_inst_acc) begin
      r_araddr <= inst_sram_addr;
      r_arsize <= c_inst_size;
      r_arid   <= ID_INST;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_awaddr <= 32'd0;
      r_awsize <= 3'd0;
      r_wdata  <= 32'd0;
      r_wstrb  <= 4'd0;
    end else if (w_data_wr_acc) begin
      r_awaddr <= data_sram_addr;
      r_awsize <= {1'b0, data_sram_size};
      r_wdata  <= data_sram_wdata;
      r_wstrb  <= data_sram_wstrb;
    end
  end

  // Per-channel completion flags let AW and W retire in either order.
  always_ff @(posedge clk) begin
    if (reset || (w_wstate_nxt != W_AW)) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (w_aw_fire) r_aw_done <= 1'b1;
      if (w_w_fire)  r_w_done  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_data_busy <= 1'b0;
    else if (w_data_rd_acc | w_data_wr_acc)
      r_data_busy <= 1'b1;
    else if (data_sram_data_ok)
      r_data_busy <= 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_axi_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sram_axi_bridge : directed scenarios plus a randomized CPU/slave  |
// |                      environment with a memory reference. Rev 1.0    |
// +----------------------------------------------------------------------+
module tb_sram_axi_bridge;

  logic        clk, reset;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  sram_axi_bridge u_dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
    .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
    .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ihash(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] v;
    v = old;
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    return v;
  endfunction

  task automatic idle_inputs();
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_wstrb = 0;
    inst_sram_addr = 0; inst_sram_wdata = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 0; data_sram_wstrb = 0;
    data_sram_addr = 0; data_sram_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = 4'd1; bresp = 0; bvalid = 0;
  endtask

  // Reference state for the randomized phase.
  logic [31:0] ref_mem [256];
  logic [31:0] slv_mem [256];
  bit          i_on, i_wait, d_on, d_wait, d_inf_wr;
  logic [31:0] i_exp, d_exp;
  bit          ar_exp_on;
  logic [3:0]  ar_exp_id;
  logic [31:0] ar_exp_addr, w_exp_addr, w_exp_data;
  logic [2:0]  ar_exp_size, w_exp_size;
  logic [3:0]  w_exp_strb;
  bit          r_pend, aw_got, w_got, both_before;
  int          r_dly, b_dly;
  logic [3:0]  r_id_q;
  logic [31:0] r_data_q, s_waddr, s_wdata;
  logic [3:0]  s_wstrb;
  bit          p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
  logic [31:0] p_araddr, p_awaddr, p_wdata;
  int          n_i_done, n_d_rd, n_d_wr;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    reset = 1;
    inst_sram_req = 1; data_sram_req = 1;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_arvalid", arvalid, 0); chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);   chk("rst_rready", rready, 0);
    chk("rst_bready", bready, 0);
    chk("rst_i_aok", inst_sram_addr_ok, 0); chk("rst_d_aok", data_sram_addr_ok, 0);
    chk("rst_i_dok", inst_sram_data_ok, 0); chk("rst_d_dok", data_sram_data_ok, 0);
    chk("rst_araddr", araddr, 0); chk("rst_awaddr", awaddr, 0); chk("rst_wdata", wdata, 0);
    chk("const_len", {arlen, awlen}, 0); chk("const_burst", {arburst, awburst}, 4'b0101);
    chk("const_misc", {arlock, awlock, arcache, awcache, arprot, awprot}, 0);
    chk("const_ids", {awid, wid, wlast}, 9'b0001_0001_1);
    idle_inputs();

    // Instruction read, minimum latency.
    @(negedge clk); reset = 0;
    @(negedge clk); inst_sram_req = 1; inst_sram_addr = 32'h1C00_0000; arready = 1;
    #1 chk("t1_aok", inst_sram_addr_ok, 1);
    @(negedge clk); inst_sram_req = 0;
    #1 chk("t1_arvalid", arvalid, 1); chk("t1_arid", arid, 0);
    chk("t1_araddr", araddr, 32'h1C00_0000); chk("t1_arsize", arsize, 3'd2);
    @(negedge clk); arready = 0; rvalid = 1; rid = 0; rdata = 32'h0280_0421;
    #1 chk("t1_dok", inst_sram_data_ok, 1); chk("t1_rdata", inst_sram_rdata, 32'h0280_0421);
    chk("t1_rready", rready, 1); chk("t1_d_dok", data_sram_data_ok, 0);
    @(negedge clk); rvalid = 0;
    #1 chk("t1_pulse", inst_sram_data_ok, 0); chk("t1_rready_off", rready, 0);

    // Simultaneous reads: data wins.
    @(negedge clk); inst_sram_req = 1; inst_sram_addr = 32'h1C00_0040;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h1000; data_sram_size = 2; arready = 1;
    #1 chk("t2_d_aok", data_sram_addr_ok, 1); chk("t2_i_aok", inst_sram_addr_ok, 0);
    @(negedge clk); data_sram_req = 0;
    #1 chk("t2_arid", arid, 1); chk("t2_araddr", araddr, 32'h1000);
    chk("t2_i_wait", inst_sram_addr_ok, 0);
    @(negedge clk); rvalid = 1; rid = 1; rdata = 32'h1122_3344;
    #1 chk("t2_d_dok", data_sram_data_ok, 1); chk("t2_d_rdata", data_sram_rdata, 32'h1122_3344);
    chk("t2_i_dok", inst_sram_data_ok, 0); chk("t2_i_aok_rr", inst_sram_addr_ok, 0);
    @(negedge clk); rvalid = 0;
    #1 chk("t2_i_aok_late", inst_sram_addr_ok, 1);
    @(negedge clk); inst_sram_req = 0;
    #1 chk("t2_arid_i", arid, 0); chk("t2_araddr_i", araddr, 32'h1C00_0040);
    @(negedge clk); rvalid = 1; rid = 0; rdata = 32'h5566_7788;
    #1 chk("t2_i_dok2", inst_sram_data_ok, 1);
    @(negedge clk); rvalid = 0; arready = 0;

    // Write with slow W channel, then a read held off by data_busy.
    @(negedge clk); data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h2000;
    data_sram_wdata = 32'hDEAD_BEEF; data_sram_wstrb = 4'hF; data_sram_size = 2;
    awready = 1; wready = 0;
    #1 chk("t3_aok", data_sram_addr_ok, 1);
    @(negedge clk); data_sram_wr = 0; data_sram_addr = 32'h2004;
    #1 chk("t3_awvalid", awvalid, 1); chk("t3_wvalid", wvalid, 1);
    chk("t3_awaddr", awaddr, 32'h2000); chk("t3_wdata", wdata, 32'hDEAD_BEEF);
    chk("t3_wstrb", wstrb, 4'hF); chk("t3_awsize", awsize, 3'd2);
    chk("t3_busy1", data_sram_addr_ok, 0);
    @(negedge clk);
    #1 chk("t3_aw_drop", awvalid, 0); chk("t3_w_hold", wvalid, 1);
    chk("t3_w_stable", wdata, 32'hDEAD_BEEF); chk("t3_busy2", data_sram_addr_ok, 0);
    @(negedge clk);
    #1 chk("t3_w_hold2", wvalid, 1); chk("t3_busy3", data_sram_addr_ok, 0);
    @(negedge clk); wready = 1;
    #1 chk("t3_w_hold3", wvalid, 1); chk("t3_bready0", bready, 0);
    @(negedge clk); wready = 0; bvalid = 1;
    #1 chk("t3_bready", bready, 1); chk("t3_dok", data_sram_data_ok, 1);
    chk("t3_busy_b", data_sram_addr_ok, 0); chk("t3_w_off", wvalid, 0);
    @(negedge clk); bvalid = 0; arready = 1;
    #1 chk("t3_dok_pulse", data_sram_data_ok, 0); chk("t5_rd_aok", data_sram_addr_ok, 1);
    @(negedge clk); data_sram_req = 0;
    #1 chk("t5_araddr", araddr, 32'h2004); chk("t5_arid", arid, 1);
    @(negedge clk); rvalid = 1; rid = 1; rdata = 32'hCAFE_F00D;
    #1 chk("t5_dok", data_sram_data_ok, 1); chk("t5_rdata", data_sram_rdata, 32'hCAFE_F00D);
    @(negedge clk); rvalid = 0; arready = 0;

    // Byte read, with arready stalled one cycle.
    @(negedge clk); data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h2003; data_sram_size = 0;
    #1 chk("t4_aok", data_sram_addr_ok, 1);
    @(negedge clk); data_sram_req = 0; data_sram_addr = 32'hFFFF_FFFF; data_sram_size = 2;
    #1 chk("t4_arsize", arsize, 3'd0); chk("t4_araddr", araddr, 32'h2003);
    @(negedge clk); arready = 1;
    #1 chk("t4_arvalid_hold", arvalid, 1); chk("t4_araddr_hold", araddr, 32'h2003);
    @(negedge clk); arready = 0; rvalid = 1; rid = 1;
    #1 chk("t4_dok", data_sram_data_ok, 1);
    @(negedge clk); rvalid = 0;

    // Reset while waiting in R_R.
    @(negedge clk); inst_sram_req = 1; inst_sram_addr = 32'h1C00_0080; arready = 1;
    #1 chk("t6_aok", inst_sram_addr_ok, 1);
    @(negedge clk); inst_sram_req = 0;
    #1 chk("t6_arvalid", arvalid, 1);
    @(negedge clk); arready = 0; reset = 1;
    #1 chk("t6_in_rr", rready, 1); chk("t6_no_dok", inst_sram_data_ok, 0);
    @(negedge clk); reset = 0;
    #1 chk("t6_arvalid_off", arvalid, 0); chk("t6_rready_off", rready, 0);
    @(negedge clk); rvalid = 1; rid = 0; inst_sram_req = 1; inst_sram_addr = 32'h1C00_00C0;
    #1 chk("t6_stray_dok", inst_sram_data_ok, 0); chk("t6_idle_aok", inst_sram_addr_ok, 1);
    @(negedge clk); rvalid = 0; inst_sram_req = 0; reset = 1;
    @(negedge clk); idle_inputs();
    for (int k = 0; k < 256; k++) begin
      ref_mem[k] = (k * 32'h0101_0101) ^ 32'h5A5A_0000;
      slv_mem[k] = ref_mem[k];
    end
    @(negedge clk); reset = 0;

    // Randomized traffic against the memory reference.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (cyc < 3700) begin
        if (!i_on && !i_wait && $urandom_range(0, 2) == 0) begin
          i_on = 1; inst_sram_addr = 32'h1C00_0000 | ($urandom & 32'h0000_FFFC);
        end
        if (!d_on && $urandom_range(0, 2) == 0) begin
          d_on = 1; data_sram_wr = 1'($urandom_range(0, 1));
          data_sram_addr = $urandom & 32'h3FF; data_sram_size = 2'($urandom_range(0, 2));
          data_sram_wdata = $urandom; data_sram_wstrb = 4'($urandom_range(1, 15));
        end
      end
      inst_sram_req = i_on; data_sram_req = d_on;
      arready = ($urandom_range(0, 2) != 0);
      rvalid  = r_pend && (r_dly == 0); rid = r_id_q; rdata = r_data_q;
      awready = !aw_got && ($urandom_range(0, 1) == 1);
      wready  = !w_got && ($urandom_range(0, 1) == 1);
      bvalid  = aw_got && w_got && (b_dly == 0);
      #1;
      if (r_pend && r_dly > 0) r_dly--;
      if (aw_got && w_got && b_dly > 0) b_dly--;
      if (p_arv && !p_arr) begin chk("ar_hold_v", arvalid, 1); chk("ar_hold_a", araddr, p_araddr); end
      if (p_awv && !p_awr) begin chk("aw_hold_v", awvalid, 1); chk("aw_hold_a", awaddr, p_awaddr); end
      if (p_wv && !p_wr)   begin chk("w_hold_v", wvalid, 1);   chk("w_hold_d", wdata, p_wdata); end
      if (inst_sram_addr_ok) begin
        chk("i_aok_req", inst_sram_req, 1); chk("i_aok_idle", i_wait, 0);
        chk("arb_data_first", data_sram_req && !data_sram_wr && !d_wait, 0);
        i_on = 0; i_wait = 1; i_exp = ihash(inst_sram_addr);
        ar_exp_on = 1; ar_exp_id = 0; ar_exp_addr = inst_sram_addr; ar_exp_size = 3'd2;
      end
      if (data_sram_addr_ok) begin
        chk("d_aok_req", data_sram_req, 1); chk("d_aok_busy", d_wait, 0);
        d_on = 0; d_wait = 1; d_inf_wr = data_sram_wr;
        if (data_sram_wr) begin
          w_exp_addr = data_sram_addr; w_exp_size = {1'b0, data_sram_size};
          w_exp_data = data_sram_wdata; w_exp_strb = data_sram_wstrb;
          ref_mem[data_sram_addr[9:2]] = merge(ref_mem[data_sram_addr[9:2]], data_sram_wdata, data_sram_wstrb);
        end else begin
          d_exp = ref_mem[data_sram_addr[9:2]];
          ar_exp_on = 1; ar_exp_id = 1; ar_exp_addr = data_sram_addr;
          ar_exp_size = {1'b0, data_sram_size};
        end
      end
      if (arvalid && arready) begin
        chk("ar_expected", ar_exp_on, 1); chk("arid", arid, ar_exp_id);
        chk("araddr", araddr, ar_exp_addr); chk("arsize", arsize, ar_exp_size);
        ar_exp_on = 0; r_pend = 1; r_dly = $urandom_range(0, 3); r_id_q = arid;
        r_data_q = (araddr[31:28] == 4'h1) ? ihash(araddr) : slv_mem[araddr[9:2]];
      end
      if (rvalid && rready) begin
        if (rid == 4'd0) chk("r_to_inst", inst_sram_data_ok, 1);
        else chk("r_to_data", data_sram_data_ok, 1);
        r_pend = 0;
      end
      if (inst_sram_data_ok) begin
        chk("i_dok_wait", i_wait, 1); chk("i_rdata", inst_sram_rdata, i_exp);
        i_wait = 0; n_i_done++;
      end
      if (data_sram_data_ok) begin
        chk("d_dok_wait", d_wait, 1);
        if (d_inf_wr) begin chk("d_wok_b", bvalid && bready, 1); n_d_wr++; end
        else begin chk("d_rdata", data_sram_rdata, d_exp); n_d_rd++; end
        d_wait = 0;
      end
      if (bvalid && bready) begin
        chk("b_dok", data_sram_data_ok, 1);
        slv_mem[s_waddr[9:2]] = merge(slv_mem[s_waddr[9:2]], s_wdata, s_wstrb);
        aw_got = 0; w_got = 0;
      end
      both_before = aw_got && w_got;
      if (awvalid && awready) begin
        chk("awaddr", awaddr, w_exp_addr); chk("awsize", awsize, w_exp_size); chk("awid", awid, 1);
        aw_got = 1; s_waddr = awaddr;
      end
      if (wvalid && wready) begin
        chk("wdata", wdata, w_exp_data); chk("wstrb", wstrb, w_exp_strb);
        chk("wlast_wid", {wlast, wid}, 5'b1_0001);
        w_got = 1; s_wdata = wdata; s_wstrb = wstrb;
      end
      if (!both_before && aw_got && w_got) b_dly = $urandom_range(0, 3);
      p_arv = arvalid; p_arr = arready; p_araddr = araddr;
      p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
      p_wv = wvalid;   p_wr = wready;   p_wdata = wdata;
    end
    chk("drain_idle", {i_on, i_wait, d_on, d_wait}, 0);
    chk("inst_traffic", n_i_done > 50, 1);
    chk("dread_traffic", n_d_rd > 50, 1);
    chk("dwrite_traffic", n_d_wr > 50, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
